// File: rtl/imem_prog.sv
// Instruction memory with a zeroing sweep after reset and a streamed program-load port.
// Latency: fetch returns q/q_valid one cycle after rd_en; done pulses the cycle after the final load word.
// Backpressure: ld_ready is high only while loading; ld_valid gaps stall the load indefinitely.
module imem_prog #(
    parameter int N  = 32,
    parameter int AW = 6
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [AW-1:0] addr,
    input  logic          rd_en,
    output logic [N-1:0]  q,
    output logic          q_valid,
    input  logic          load_start,
    input  logic [AW-1:0] ld_base,
    input  logic [AW:0]   ld_len,
    input  logic          ld_valid,
    input  logic [N-1:0]  ld_data,
    output logic          ld_ready,
    output logic          busy,
    output logic          done
);

    localparam int DEPTH = 1 << AW;

    typedef enum logic [1:0] {
        ST_CLEAR = 2'd0,
        ST_RUN   = 2'd1,
        ST_LOAD  = 2'd2
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [AW-1:0] clr_ptr;
    logic [AW-1:0] wr_ptr;
    logic [AW:0]   remain;
    logic [N-1:0]  mem [DEPTH];

    logic          mem_we;
    logic [AW-1:0] mem_wa;
    logic [N-1:0]  mem_wd;

    logic          ld_hs;
    logic          last_hs;
    logic          clr_last;
    logic          start_load;
    logic          start_empty;

    assign ld_hs       = ld_valid & ld_ready;
    assign last_hs     = ld_hs && (remain == (AW+1)'(1));
    assign clr_last    = (clr_ptr == {AW{1'b1}});
    assign start_load  = (state == ST_RUN) && load_start && (ld_len != '0);
    assign start_empty = (state == ST_RUN) && load_start && (ld_len == '0);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= ST_CLEAR;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_CLEAR: if (clr_last)   state_nxt = ST_RUN;
            ST_RUN:   if (start_load) state_nxt = ST_LOAD;
            ST_LOAD:  if (last_hs)    state_nxt = ST_RUN;
            default:                  state_nxt = ST_CLEAR;
        endcase
    end

    always_comb begin
        ld_ready = 1'b0;
        busy     = 1'b1;
        mem_we   = 1'b0;
        mem_wa   = clr_ptr;
        mem_wd   = '0;
        case (state)
            ST_CLEAR: begin
                mem_we = 1'b1;
                mem_wa = clr_ptr;
                mem_wd = '0;
            end
            ST_RUN: begin
                busy = 1'b0;
            end
            ST_LOAD: begin
                ld_ready = 1'b1;
                mem_we   = ld_hs;
                mem_wa   = wr_ptr;
                mem_wd   = ld_data;
            end
            default: begin
                busy = 1'b1;
            end
        endcase
    end

    // Pointer wraps naturally at 2^AW, so oversize loads overwrite earlier words.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            clr_ptr <= '0;
            wr_ptr  <= '0;
            remain  <= '0;
            q       <= '0;
            q_valid <= 1'b0;
            done    <= 1'b0;
        end else begin
            done    <= start_empty || (state == ST_LOAD && last_hs);
            q_valid <= (state == ST_RUN) && rd_en;
            if (state == ST_RUN && rd_en) begin
                q <= mem[addr];
            end
            if (state == ST_CLEAR) begin
                clr_ptr <= clr_ptr + AW'(1);
            end
            if (state == ST_RUN && load_start) begin
                wr_ptr <= ld_base;
                remain <= ld_len;
            end else if (state == ST_LOAD && ld_hs) begin
                wr_ptr <= wr_ptr + AW'(1);
                remain <= remain - (AW+1)'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_wa] <= mem_wd;
        end
    end

endmodule

// File: doc/imem_prog.md
IMEM_PROG -- requirements
Module: imem_prog

Interface
REQ-001 Parameter N, default 32, instruction word width in bits.
REQ-002 Parameter AW, default 6, address width; depth = 2^AW words.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 addr  input  AW  fetch word address.
REQ-006 rd_en  input  1  fetch request.
REQ-007 q  output  N  fetched instruction word, registered.
REQ-008 q_valid  output  1  q holds data for the request of the previous cycle.
REQ-009 load_start  input  1  begin a program load.
REQ-010 ld_base  input  AW  first word address of the load, sampled with load_start.
REQ-011 ld_len  input  AW+1  number of words to load, sampled with load_start.
REQ-012 ld_valid  input  1  ld_data carries a word.
REQ-013 ld_data  input  N  program word.
REQ-014 ld_ready  output  1  block accepts a word this cycle.
REQ-015 busy  output  1  high in every state except RUN.
REQ-016 done  output  1  one-cycle pulse at load completion.

Function
REQ-017 The block SHALL have states CLEAR, RUN and LOAD.
REQ-018 In CLEAR, one word per cycle SHALL be written to zero, from address 0 to 2^AW-1; after the write to 2^AW-1 the next state SHALL be RUN.
REQ-019 CLEAR SHALL take exactly 2^AW cycles (64 at default), and the first RUN cycle SHALL follow.
REQ-020 In RUN, rd_en=1 at edge k SHALL give q=mem[addr] and q_valid=1 after edge k.
REQ-021 With rd_en=0 in RUN, q_valid SHALL be 0 and q SHALL hold its last value.
REQ-022 In CLEAR and LOAD, rd_en SHALL be ignored, q_valid SHALL be 0 and q SHALL hold.
REQ-023 In RUN, load_start=1 SHALL latch ld_base into a write pointer and ld_len into a remaining count.
REQ-024 If the latched ld_len is nonzero, the next state SHALL be LOAD.
REQ-025 If the latched ld_len is zero, the block SHALL stay in RUN, write nothing, and pulse done on the next cycle.
REQ-026 Fetch and load_start in the same RUN cycle SHALL both take effect: the read completes and LOAD starts next cycle.
REQ-027 ld_ready SHALL be 1 exactly in LOAD.
REQ-028 A handshake is ld_valid&ld_ready at an edge; each handshake SHALL write ld_data to mem[pointer], increment the pointer modulo 2^AW (wrap-around), and decrement the count.
REQ-029 When the handshake taking the count to 0 occurs, the next state SHALL be RUN and done SHALL be 1 for that following cycle only.
REQ-030 ld_valid=0 in LOAD SHALL stall with no write; there is no timeout.
REQ-031 load_start outside RUN SHALL be ignored.
REQ-032 ld_len > 2^AW SHALL wrap and overwrite earlier words; the last written value wins.
REQ-033 Memory SHALL be a plain array with no reset term; zeroing is done only by CLEAR.

Reset
REQ-034 While reset=0 the block SHALL hold: state=CLEAR, clear pointer=0, q=0, q_valid=0, ld_ready=0, done=0, busy=1.
REQ-035 Deasserting reset SHALL start the CLEAR sweep at address 0 on the next edge.
REQ-036 Reset asserted mid-LOAD or mid-CLEAR SHALL abort immediately; the partial load is discarded by the following CLEAR.

Verification
REQ-037 Release reset, idle 64 cycles -> busy falls on cycle 64; rd_en at addr 0..63 -> q=0, q_valid=1 one cycle later for each.
REQ-038 load_start, ld_base=0, ld_len=3, words 32'hf8000001, 32'h8b050083, 32'hb400001f with ld_valid gaps -> ld_ready high only in LOAD; done single pulse after the 3rd handshake; reads of addr 0..2 return those words.
REQ-039 ld_base=62, ld_len=4, words A,B,C,D -> mem[62]=A, mem[63]=B, mem[0]=C, mem[1]=D.
REQ-040 ld_len=0 -> no writes, busy stays 0, done pulses once the next cycle.
REQ-041 Reset pulled low after 2 of 5 load words -> outputs at reset values at once; after release, 64-cycle CLEAR; then all reads return 0.
REQ-042 rd_en=1, addr=5 and load_start in the same RUN cycle -> q=mem[5], q_valid=1 next cycle; LOAD entered that same cycle; rd_en during LOAD gives q_valid=0.
